// File: rtl/keypad_scan_4x4_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, frame results,
// column reset pattern and small bit-counting functions.
package keypad_scan_4x4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_PRESSED = 2'd2
    } kp_state_e;

    typedef enum logic [1:0] {
        FRAME_NONE   = 2'd0,
        FRAME_SINGLE = 2'd1,
        FRAME_MULTI  = 2'd2
    } frame_res_e;

    localparam logic [3:0] COL_RESET = 4'b1110;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest set bit; only meaningful when v is non-zero.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scan_4x4_debounce.sv
// Frame-level debounce FSM: accepts a single stable key after DEBOUNCE_SCANS frames,
// emits a one-cycle valid pulse and holds key_held until the release is debounced.
module keypad_scan_4x4_debounce
    import keypad_scan_4x4_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_done,
    input  logic       frame_single,
    input  logic [3:0] frame_code,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    kp_state_e        state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic [CNT_W-1:0] cnt_inc, rcnt_inc;
    logic             same_key;

    assign cnt_inc  = cnt_q + CNT_ONE;
    assign rcnt_inc = rcnt_q + CNT_ONE;
    assign same_key = frame_single && (frame_code == cand_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (frame_done) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_single) begin
                        cand_d = frame_code;
                        cnt_d  = CNT_ONE;
                        if (DEB_LAST == CNT_ONE) begin
                            state_d = ST_PRESSED;
                            code_d  = frame_code;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            rcnt_d  = '0;
                        end else begin
                            state_d = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (same_key) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            state_d = ST_PRESSED;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            rcnt_d  = '0;
                        end
                    end else if (frame_single) begin
                        cand_d = frame_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    // A different key while held counts toward release, never a new press.
                    if (same_key) begin
                        rcnt_d = '0;
                    end else if (rcnt_inc == DEB_LAST) begin
                        state_d = ST_IDLE;
                        held_d  = 1'b0;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 keypad scanner: rotates an active-low column strobe, synchronises the rows,
// collects one frame per four columns and hands the frame result to the debouncer.
module keypad_scan_4x4
    import keypad_scan_4x4_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       key_col_q, key_col_d;
    logic [3:0]       row_s1_q, row_s_q;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [3:0]       fcode_q, fcode_d;

    logic             tick;
    logic [3:0]       pressed;
    logic [2:0]       sum;
    logic [1:0]       fcnt_nx;
    logic [3:0]       code_nx;
    logic             frame_done;
    frame_res_e       frame_res;

    assign tick       = (div_q == DIV_LAST);
    assign frame_done = tick && (col_idx_q == 2'd3);
    assign pressed    = ~row_s_q;

    always_comb begin
        // Saturate the pressed-bit count at 2: only none/one/many matters.
        sum     = {1'b0, fcnt_q} + popcount4(pressed);
        fcnt_nx = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_nx = (fcnt_q == 2'd0) ? {lowest_set(pressed), col_idx_q} : fcode_q;
        unique case (fcnt_nx)
            2'd0:    frame_res = FRAME_NONE;
            2'd1:    frame_res = FRAME_SINGLE;
            default: frame_res = FRAME_MULTI;
        endcase
    end

    always_comb begin
        div_d     = div_q + 1'b1;
        col_idx_d = col_idx_q;
        key_col_d = key_col_q;
        fcnt_d    = fcnt_q;
        fcode_d   = fcode_q;
        if (tick) begin
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            key_col_d = ~(4'b0001 << col_idx_d);
            if (frame_done) begin
                fcnt_d  = '0;
                fcode_d = '0;
            end else begin
                fcnt_d  = fcnt_nx;
                fcode_d = code_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            col_idx_q <= '0;
            key_col_q <= COL_RESET;
            row_s1_q  <= 4'b1111;
            row_s_q   <= 4'b1111;
            fcnt_q    <= '0;
            fcode_q   <= '0;
        end else begin
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            key_col_q <= key_col_d;
            row_s1_q  <= key_row;
            row_s_q   <= row_s1_q;
            fcnt_q    <= fcnt_d;
            fcode_q   <= fcode_d;
        end
    end

    assign key_col = key_col_q;

    keypad_scan_4x4_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .frame_done  (frame_done),
        .frame_single(frame_res == FRAME_SINGLE),
        .frame_code  (code_nx),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-clk frames);
// a keypad model pulls rows low for each pressed key whose column is driven.
module tb_keypad_scan_4x4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] mask = '0;
    int errors = 0;
    int checks = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    keypad_scan_4x4 #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always_comb begin
        key_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) pulses++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
    endtask

    task automatic test_reset();
        mask = '0;
        apply_reset();
        checks++; if (key_col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", key_col); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_col;
        for (int i = 1; i <= 8; i++) begin
            cyc(4);
            exp_col = ~(4'b0001 << (i % 4));
            checks++; if (key_col !== exp_col) begin errors++; $display("FAIL scan_col%0d: got %b expected %b", i, key_col, exp_col); end
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL scan_no_valid: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_press();
        mask = 16'h0040;
        apply_reset();
        cyc(47);
        checks++; if (key_valid !== 1'b0 || pulses !== 0) begin errors++; $display("FAIL press_early: got valid=%b pulses=%0d expected 0/0", key_valid, pulses); end
        cyc(1);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b expected 1", key_valid); end
        checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL press_code: got %0d expected 6", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b expected 1", key_held); end
        cyc(1);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_pulse_width: got %b expected 0", key_valid); end
        cyc(31);
        mask = '0;
        cyc(47);
        checks++; if (key_held !== 1'b1 || pulses !== 1) begin errors++; $display("FAIL release_early: got held=%b pulses=%0d expected 1/1", key_held, pulses); end
        cyc(1);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b expected 0", key_held); end
        checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL release_code_hold: got %0d expected 6", key_code); end
    endtask

    task automatic test_short_press();
        mask = 16'h0040;
        apply_reset();
        cyc(32);
        mask = '0;
        cyc(16);
        mask = 16'h0040;
        cyc(47);
        checks++; if (pulses !== 0 || key_valid !== 1'b0) begin errors++; $display("FAIL short_no_pulse: got pulses=%0d valid=%b expected 0/0", pulses, key_valid); end
        cyc(1);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL short_repress: got valid=%b code=%0d expected 1/6", key_valid, key_code); end
    endtask

    task automatic test_multi();
        mask = 16'h0202;
        apply_reset();
        cyc(80);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL multi_pulses: got %0d expected 0", pulses); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held: got %b expected 0", key_held); end
    endtask

    task automatic test_bounce();
        mask = 16'h0008;
        apply_reset();
        cyc(48);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd3) begin errors++; $display("FAIL bounce_accept: got valid=%b code=%0d expected 1/3", key_valid, key_code); end
        mask = '0;
        cyc(16);
        mask = 16'h0008;
        cyc(32);
        checks++; if (key_held !== 1'b1 || pulses !== 1) begin errors++; $display("FAIL bounce_held: got held=%b pulses=%0d expected 1/1", key_held, pulses); end
        mask = 16'h1000;
        cyc(47);
        checks++; if (key_held !== 1'b1 || pulses !== 1) begin errors++; $display("FAIL switch_held: got held=%b pulses=%0d expected 1/1", key_held, pulses); end
        cyc(1);
        checks++; if (key_held !== 1'b0 || key_code !== 4'd3) begin errors++; $display("FAIL switch_release: got held=%b code=%0d expected 0/3", key_held, key_code); end
        cyc(47);
        checks++; if (pulses !== 1 || key_valid !== 1'b0) begin errors++; $display("FAIL switch_early: got pulses=%0d valid=%b expected 1/0", pulses, key_valid); end
        cyc(1);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd12) begin errors++; $display("FAIL switch_accept: got valid=%b code=%0d expected 1/12", key_valid, key_code); end
    endtask

    task automatic test_reset_mid();
        mask = 16'h0040;
        apply_reset();
        cyc(48);
        checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL mid_pre_code: got %0d expected 6", key_code); end
        mask = '0;
        cyc(48);
        mask = 16'h0008;
        cyc(40);
        pulses = 0;
        rst = 1'b1;
        cyc(1);
        checks++; if (key_col !== 4'b1110 || key_code !== 4'd0) begin errors++; $display("FAIL mid_reset_outs: got col=%b code=%0d expected 1110/0", key_col, key_code); end
        checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got valid=%b held=%b expected 0/0", key_valid, key_held); end
        cyc(1);
        rst = 1'b0;
        cyc(47);
        checks++; if (pulses !== 0 || key_held !== 1'b0) begin errors++; $display("FAIL mid_early: got pulses=%0d held=%b expected 0/0", pulses, key_held); end
        cyc(1);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd3 || key_held !== 1'b1) begin errors++; $display("FAIL mid_accept: got valid=%b code=%0d held=%b expected 1/3/1", key_valid, key_code, key_held); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press();
        test_short_press();
        test_multi();
        test_bounce();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
